fios_res_collector: RTL

Downstream stage of the FIOS Montgomery multiplier. It captures the serial 17-bit result words (least significant first) as the multiplier emits them. While capturing, it computes the final conditional subtraction T − p word by word. It then replays the reduced result (T if T < p, else T − p) over a valid/ready stream to the consumer.

---
 rtl/fios_res_collector_if.sv | 22 ++
 rtl/fios_res_collector.sv | 127 ++++++++++++
 2 files changed

// File: rtl/fios_res_collector_if.sv
// Result-word stream bundle for the FIOS collector: word input from the
// multiplier and the valid/ready replay toward the consumer.
interface fios_res_collector_if #(
    parameter int W = 17
);
    logic [W-1:0] res_i;
    logic         res_valid_i;
    logic [W-1:0] res_o;
    logic         res_valid_o;
    logic         res_ready_i;
    logic         res_last_o;

    modport master (
        input  res_i, res_valid_i, res_ready_i,
        output res_o, res_valid_o, res_last_o
    );

    modport slave (
        output res_i, res_valid_i, res_ready_i,
        input  res_o, res_valid_o, res_last_o
    );
endinterface

// File: rtl/fios_res_collector.sv
// Captures the serial Montgomery result, computes T - p on the fly and
// replays the reduced value (T or T - p) over a valid/ready stream.
module fios_res_collector #(
    parameter int S = 8,
    parameter int W = 17
) (
    input  logic                   clock_i,
    input  logic                   reset_n_i,
    input  logic                   start_i,
    input  logic [S*W-1:0]         p_i,
    fios_res_collector_if.master   res,
    output logic                   busy_o,
    output logic                   overflow_o
);
    localparam int KW = (S > 1) ? $clog2(S) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(S - 1);

    typedef enum logic [1:0] {IDLE, COLLECT, OUTPUT} state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] k_q;
    logic [KW-1:0] k_nxt;
    logic          borrow_q;
    logic          sel_d_q;

    logic [W-1:0]  t_mem [S];
    logic [W-1:0]  d_mem [S];

    logic [W-1:0]  p_word;
    logic [W-1:0]  diff;
    logic          b_out;
    logic [W-1:0]  w0_t, w0_d;
    logic          col_fire, out_fire;

    assign p_word = p_i[k_q*W +: W];
    assign {b_out, diff} = {1'b0, res.res_i} - {1'b0, p_word} - {{W{1'b0}}, borrow_q};

    assign col_fire = (state_q == COLLECT) && res.res_valid_i && !start_i;
    assign out_fire = (state_q == OUTPUT) && res.res_valid_o && res.res_ready_i;
    assign k_nxt    = k_q + 1'b1;

    // With a single word, word 0 is the one arriving right now, not yet stored.
    assign w0_t = (S == 1) ? res.res_i : t_mem[0];
    assign w0_d = (S == 1) ? diff      : d_mem[0];

    assign busy_o = (state_q != IDLE);

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) state_q <= IDLE;
        else            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (start_i) begin
            state_d = COLLECT;
        end else begin
            case (state_q)
                COLLECT: if (col_fire && k_q == K_LAST) state_d = OUTPUT;
                OUTPUT:  if (out_fire && k_q == K_LAST) state_d = IDLE;
                default: state_d = state_q;
            endcase
        end
    end

    // Word storage carries no reset; only control state is cleared.
    always_ff @(posedge clock_i) begin
        if (col_fire) begin
            t_mem[k_q] <= res.res_i;
            d_mem[k_q] <= diff;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            k_q             <= '0;
            borrow_q        <= 1'b0;
            sel_d_q         <= 1'b0;
            res.res_o       <= '0;
            res.res_valid_o <= 1'b0;
            res.res_last_o  <= 1'b0;
            overflow_o      <= 1'b0;
        end else if (start_i) begin
            k_q             <= '0;
            borrow_q        <= 1'b0;
            sel_d_q         <= 1'b0;
            res.res_o       <= '0;
            res.res_valid_o <= 1'b0;
            res.res_last_o  <= 1'b0;
            overflow_o      <= 1'b0;
        end else begin
            // No backpressure to the multiplier: words outside COLLECT are lost.
            if (res.res_valid_i && state_q != COLLECT) overflow_o <= 1'b1;
            case (state_q)
                COLLECT: begin
                    if (col_fire) begin
                        borrow_q <= b_out;
                        if (k_q == K_LAST) begin
                            k_q             <= '0;
                            sel_d_q         <= ~b_out;
                            res.res_o       <= b_out ? w0_t : w0_d;
                            res.res_valid_o <= 1'b1;
                            res.res_last_o  <= (S == 1);
                        end else begin
                            k_q <= k_nxt;
                        end
                    end
                end
                OUTPUT: begin
                    if (out_fire) begin
                        if (k_q == K_LAST) begin
                            k_q             <= '0;
                            res.res_o       <= '0;
                            res.res_valid_o <= 1'b0;
                            res.res_last_o  <= 1'b0;
                        end else begin
                            k_q            <= k_nxt;
                            res.res_o      <= sel_d_q ? d_mem[k_nxt] : t_mem[k_nxt];
                            res.res_last_o <= (k_nxt == K_LAST);
                        end
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
